// File: rtl/melody_pkg.sv
`default_nettype none
// ============================================================================
// Module      : melody_pkg
// Description : Shared constants, duration decode and FSM states for the
//               melody sequencer.
// Revision    : 1.0
// ============================================================================
package melody_pkg;

    localparam logic [7:0] REST_CODE = 8'h80;
    localparam logic [5:0] END_CODE  = 6'h3F;

    localparam logic [5:0] DUR_16TH    = 6'd0;
    localparam logic [5:0] DUR_8TH     = 6'd1;
    localparam logic [5:0] DUR_QUARTER = 6'd2;
    localparam logic [5:0] DUR_HALF    = 6'd3;
    localparam logic [5:0] DUR_WHOLE   = 6'd4;
    localparam logic [5:0] DUR_DOT8TH  = 6'd5;

    // Semitone offsets from A4
    localparam logic signed [7:0] C4 = -8'sd9;
    localparam logic signed [7:0] D4 = -8'sd7;
    localparam logic signed [7:0] E4 = -8'sd5;
    localparam logic signed [7:0] F4 = -8'sd4;
    localparam logic signed [7:0] G4 = -8'sd2;
    localparam logic signed [7:0] A4 = 8'sd0;
    localparam logic signed [7:0] B4 = 8'sd2;
    localparam logic signed [7:0] C5 = 8'sd3;
    localparam logic signed [7:0] D5 = 8'sd5;
    localparam logic signed [7:0] E5 = 8'sd7;
    localparam logic signed [7:0] F5 = 8'sd8;
    localparam logic signed [7:0] G5 = 8'sd10;
    localparam logic signed [7:0] A5 = 8'sd12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_PLAY  = 3'd4
    } state_e;

    function automatic logic [4:0] dur_to_ticks(input logic [5:0] code);
        logic [4:0] t;
        case (code)
            DUR_16TH:    t = 5'd1;
            DUR_8TH:     t = 5'd2;
            DUR_QUARTER: t = 5'd4;
            DUR_HALF:    t = 5'd8;
            DUR_WHOLE:   t = 5'd16;
            DUR_DOT8TH:  t = 5'd3;
            default:     t = 5'd4;
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/melody_sequencer_tick_timer.sv
`default_nettype none
// ============================================================================
// Module      : tick_timer
// Description : Tempo prescaler plus 16th-note tick down-counter.
// Revision    : 1.0
// ============================================================================
module tick_timer #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             abort_i,
    input  logic             en_i,
    input  logic [4:0]       ticks_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             expire_o
);

    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] div_q;
    logic [4:0]       ticks_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            ticks_q <= '0;
        end else if (abort_i) begin
            div_q   <= '0;
            ticks_q <= '0;
        end else if (load_i) begin
            div_q   <= div_i;
            ticks_q <= ticks_i;
        end else if (en_i) begin
            if (div_q == '0) begin
                div_q   <= div_i;
                ticks_q <= ticks_q - 5'd1;
            end else begin
                div_q   <= div_q - DIV_ONE;
            end
        end
    end

    assign expire_o = en_i && (div_q == '0) && (ticks_q == 5'd1);

endmodule
`default_nettype wire

// File: rtl/melody_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : melody_sequencer
// Description : Multi-song note sequencer walking an external 1-cycle ROM.
// Revision    : 1.0
// ============================================================================
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int SONG_W = 1,
    parameter int IDX_W  = 7,
    parameter int DIV_W  = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    loop_en,
    input  logic [SONG_W-1:0]       song_sel,
    input  logic [DIV_W-1:0]        tempo_div,
    output logic [SONG_W+IDX_W-1:0] rom_addr,
    input  logic [15:0]             rom_data,
    output logic [7:0]              note_pitch,
    output logic                    note_gate,
    output logic                    note_strobe,
    output logic                    busy,
    output logic                    done
);

    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [SONG_W-1:0]       song_q, song_d;
    logic [DIV_W-1:0]        tempo_q, tempo_d;
    logic [SONG_W+IDX_W-1:0] addr_q, addr_d;
    logic [7:0]              pitch_q, pitch_d;
    logic                    gate_q, gate_d;
    logic                    strobe_q, strobe_d;
    logic                    done_q, done_d;
    logic                    wrap_q, wrap_d;
    logic                    tmr_load;
    logic                    tmr_expire;
    logic                    is_end;
    logic                    rom_unused;

    assign rom_unused = ^rom_data[7:6];
    // A wrapped index forces END regardless of what the ROM holds there
    assign is_end     = wrap_q || (rom_data[5:0] == END_CODE);

    tick_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (tmr_load),
        .abort_i  (stop),
        .en_i     (state_q == ST_PLAY),
        .ticks_i  (dur_to_ticks(rom_data[5:0])),
        .div_i    (tempo_q),
        .expire_o (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        song_d   = song_q;
        tempo_d  = tempo_q;
        addr_d   = addr_q;
        pitch_d  = pitch_q;
        gate_d   = 1'b0;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        wrap_d   = wrap_q;
        tmr_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    song_d  = song_sel;
                    tempo_d = tempo_div;
                    idx_d   = '0;
                    wrap_d  = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                addr_d  = {song_q, idx_q};
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                wrap_d = 1'b0;
                if (is_end) begin
                    if (loop_en) begin
                        idx_d   = '0;
                        state_d = ST_FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    pitch_d  = rom_data[15:8];
                    strobe_d = 1'b1;
                    tmr_load = 1'b1;
                    gate_d   = (rom_data[15:8] != REST_CODE);
                    state_d  = ST_PLAY;
                end
            end
            ST_PLAY: begin
                gate_d = gate_q;
                if (tmr_expire) begin
                    idx_d   = idx_q + IDX_ONE;
                    wrap_d  = &idx_q;
                    gate_d  = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (stop) begin
            state_d  = ST_IDLE;
            gate_d   = 1'b0;
            strobe_d = 1'b0;
            done_d   = 1'b0;
            tmr_load = 1'b0;
            pitch_d  = pitch_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            song_q   <= '0;
            tempo_q  <= '0;
            addr_q   <= '0;
            pitch_q  <= '0;
            gate_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            song_q   <= song_d;
            tempo_q  <= tempo_d;
            addr_q   <= addr_d;
            pitch_q  <= pitch_d;
            gate_q   <= gate_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
        end
    end

    assign rom_addr    = addr_q;
    assign note_pitch  = pitch_q;
    assign note_gate   = gate_q;
    assign note_strobe = strobe_q;
    assign done        = done_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_melody_sequencer
// Description : Scoreboard bench for melody_sequencer with a two-song test ROM.
// Revision    : 1.0
// ============================================================================
module tb_melody_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, loop_en;
    logic [0:0]  song_sel;
    logic [23:0] tempo_div;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data = 16'h0000;
    logic [7:0]  note_pitch;
    logic        note_gate, note_strobe, busy, done;

    typedef struct {
        bit         is_done;
        logic [7:0] pitch;
        int         t;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc    = 0;
    bit  chk_msb = 1'b0;

    melody_sequencer #(.SONG_W(1), .IDX_W(7), .DIV_W(24)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .loop_en     (loop_en),
        .song_sel    (song_sel),
        .tempo_div   (tempo_div),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .note_pitch  (note_pitch),
        .note_gate   (note_gate),
        .note_strobe (note_strobe),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Song 0: E5/8th, REST/8th, A4/quarter, END.  Song 1: 128 16th notes, pitch = index.
    function automatic logic [15:0] rom_word(input logic [7:0] a);
        logic [15:0] w;
        if (a[7]) begin
            w = {1'b0, a[6:0], 8'h00};
        end else begin
            case (a[6:0])
                7'd0:    w = 16'h0701;
                7'd1:    w = 16'h8001;
                7'd2:    w = 16'h0002;
                default: w = 16'h003F;
            endcase
        end
        return w;
    endfunction

    always @(posedge clk) rom_data <= rom_word(rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (note_strobe || done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {30'd0, note_strobe, done}, 32'd0);
                end else begin
                    ev_t ev;
                    ev = exp_q.pop_front();
                    chk("event_kind", {31'd0, done}, {31'd0, ev.is_done});
                    chk("event_time", cyc, ev.t);
                    if (!ev.is_done) chk("strobe_pitch", {24'd0, note_pitch}, {24'd0, ev.pitch});
                end
            end
            if (chk_msb && busy) chk("song_msb", {31'd0, rom_addr[7]}, 32'd1);
        end
    end

    task automatic push_note(input int t, input logic [7:0] p);
        ev_t ev;
        ev.is_done = 1'b0; ev.pitch = p; ev.t = t;
        exp_q.push_back(ev);
    endtask

    task automatic push_done(input int t);
        ev_t ev;
        ev.is_done = 1'b1; ev.pitch = 8'h00; ev.t = t;
        exp_q.push_back(ev);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic pulse_start(input logic s, input logic [23:0] d, output int t0);
        song_sel  = s;
        tempo_div = d;
        start     = 1'b1;
        t0        = cyc;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic push_song0(input int t0, input bit with_done);
        push_note(t0 + 4,  8'h07);
        push_note(t0 + 15, 8'h80);
        push_note(t0 + 26, 8'h00);
        if (with_done) push_done(t0 + 45);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        song_sel = 1'b0; tempo_div = 24'd0;
        repeat (3) @(negedge clk);
        chk("reset_addr",   {24'd0, rom_addr}, 32'd0);
        chk("reset_pitch",  {24'd0, note_pitch}, 32'd0);
        chk("reset_gate",   {31'd0, note_gate}, 32'd0);
        chk("reset_strobe", {31'd0, note_strobe}, 32'd0);
        chk("reset_busy",   {31'd0, busy}, 32'd0);
        chk("reset_done",   {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // One-shot song 0, with an ignored start mid-song
        pulse_start(1'b0, 24'd3, t0);
        push_song0(t0, 1'b1);
        wait_to(t0 + 4);  chk("s0_gate_on",  {31'd0, note_gate}, 32'd1);
        chk("s0_busy", {31'd0, busy}, 32'd1);
        chk("s0_addr0", {24'd0, rom_addr}, 32'h00);
        wait_to(t0 + 11); chk("s0_gate_last", {31'd0, note_gate}, 32'd1);
        wait_to(t0 + 12); chk("s0_gap", {31'd0, note_gate}, 32'd0);
        wait_to(t0 + 14); chk("s0_addr1", {24'd0, rom_addr}, 32'h01);
        wait_to(t0 + 15); chk("s0_rest_gate", {31'd0, note_gate}, 32'd0);
        wait_to(t0 + 20);
        begin
            int tx;
            pulse_start(1'b1, 24'd0, tx);
        end
        wait_to(t0 + 26); chk("s0_q_gate", {31'd0, note_gate}, 32'd1);
        wait_to(t0 + 41); chk("s0_q_gate_last", {31'd0, note_gate}, 32'd1);
        wait_to(t0 + 42); chk("s0_q_gate_off", {31'd0, note_gate}, 32'd0);
        wait_to(t0 + 44); chk("s0_busy_pre", {31'd0, busy}, 32'd1);
        wait_to(t0 + 45); chk("s0_busy_done", {31'd0, busy}, 32'd0);
        wait_to(t0 + 52); chk("s0_queue", exp_q.size(), 32'd0);

        // Stop during the rest, then replay from index 0
        pulse_start(1'b0, 24'd3, t0);
        push_note(t0 + 4,  8'h07);
        push_note(t0 + 15, 8'h80);
        wait_to(t0 + 18);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_busy",  {31'd0, busy}, 32'd0);
        chk("stop_gate",  {31'd0, note_gate}, 32'd0);
        chk("stop_pitch", {24'd0, note_pitch}, 32'h80);
        wait_to(t0 + 50); chk("stop_queue", exp_q.size(), 32'd0);
        pulse_start(1'b0, 24'd3, t0);
        push_song0(t0, 1'b1);
        wait_to(t0 + 4);  chk("replay_addr", {24'd0, rom_addr}, 32'h00);
        wait_to(t0 + 50); chk("replay_queue", exp_q.size(), 32'd0);

        // Looping song 0: pitch 7 returns, no done
        loop_en = 1'b1;
        pulse_start(1'b0, 24'd3, t0);
        push_song0(t0, 1'b0);
        push_note(t0 + 48, 8'h07);
        wait_to(t0 + 48); chk("loop_addr", {24'd0, rom_addr}, 32'h00);
        wait_to(t0 + 52);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        loop_en = 1'b0;
        chk("loop_stop_busy", {31'd0, busy}, 32'd0);
        wait_to(t0 + 65); chk("loop_queue", exp_q.size(), 32'd0);

        // start and stop together while idle
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        chk("startstop_idle", {31'd0, busy}, 32'd0);

        // Song 1: 128 16th notes at tempo_div 0, index wrap acts as END
        pulse_start(1'b1, 24'd0, t0);
        song_sel = 1'b0;
        for (int k = 0; k < 128; k++) push_note(t0 + 4 + 4 * k, k[7:0]);
        push_done(t0 + 516);
        wait_to(t0 + 2);  chk_msb = 1'b1;
        wait_to(t0 + 4);  chk("s1_gate_on",  {31'd0, note_gate}, 32'd1);
        wait_to(t0 + 5);  chk("s1_gate_off", {31'd0, note_gate}, 32'd0);
        wait_to(t0 + 515); chk("s1_busy_pre", {31'd0, busy}, 32'd1);
        wait_to(t0 + 516); chk("s1_busy_done", {31'd0, busy}, 32'd0);
        chk_msb = 1'b0;
        wait_to(t0 + 522); chk("s1_queue", exp_q.size(), 32'd0);

        // Asynchronous reset mid-note
        pulse_start(1'b0, 24'd3, t0);
        push_note(t0 + 4, 8'h07);
        wait_to(t0 + 6);
        chk("prerst_gate", {31'd0, note_gate}, 32'd1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_addr",  {24'd0, rom_addr}, 32'd0);
        chk("arst_pitch", {24'd0, note_pitch}, 32'd0);
        chk("arst_gate",  {31'd0, note_gate}, 32'd0);
        chk("arst_busy",  {31'd0, busy}, 32'd0);
        chk("arst_done",  {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Parametrised multi-song note sequencer. It walks a synchronous note ROM holding several songs, times each note from its duration code, and drives the pitch offset and gate into the tone/FM synthesis path.
- Successor to the fixed single-song ROM. Adds song select, runtime tempo, loop/one-shot modes, start/stop control and an in-band end marker.
- The ROM sits outside this block on a 1-cycle-latency read port.

Parameters:
- SONG_W, default 1: song-select width; 2^SONG_W songs.
- IDX_W, default 7: note-index width; 2^IDX_W note slots per song.
- DIV_W, default 24: width of the tempo divider (clocks per 16th-note tick, minus 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  single-cycle pulse; begins playback when idle.
- stop  in  1  single-cycle pulse; aborts playback.
- loop_en  in  1  1 = restart song at end marker; 0 = one-shot.
- song_sel  in  SONG_W  song number, latched on accepted start.
- tempo_div  in  DIV_W  clocks per tick minus 1, latched on accepted start.
- rom_addr  out  SONG_W+IDX_W  {song, index} to the note ROM.
- rom_data  in  16  ROM word, valid 1 cycle after rom_addr. Bits [15:8] signed pitch (0x80 = REST), [5:0] duration code.
- note_pitch  out  8  signed semitone offset from A4 for the current note.
- note_gate  out  1  high while a non-rest note sounds.
- note_strobe  out  1  1-cycle pulse on each note load, including rests.
- busy  out  1  high in any state other than IDLE.
- done  out  1  1-cycle pulse when a one-shot song completes.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, index 0, latched song/tempo 0.
- FSM states: IDLE, FETCH, WAIT, LOAD, PLAY.
- IDLE:
  - start=1 and stop=0 -> latch song_sel and tempo_div, index <- 0, go to FETCH.
  - Otherwise stay.
- FETCH: drive rom_addr = {song_latch, index}; go to WAIT. rom_addr is a registered output and holds its value through WAIT and LOAD.
- WAIT: one cycle for the ROM latency; go to LOAD.
- LOAD: decode rom_data.
  - Duration code 6'h3F is the END marker:
    - loop_en=1 -> index <- 0, go to FETCH.
    - loop_en=0 -> pulse done, go to IDLE.
    - note_pitch and note_gate are unchanged; gate is already 0.
  - Any other code:
    - note_pitch <- rom_data[15:8].
    - Pulse note_strobe.
    - ticks <- decoded tick count; div_cnt <- tempo_div_latch.
    - Go to PLAY.
- Duration decode in 16th ticks: 0->1, 1->2, 2->4, 3->8, 4->16, 5->3 (dotted eighth). Codes 6..62 are treated as 4.
- note_gate is registered. It is 1 during PLAY when the pitch is not 0x80, and 0 in IDLE/FETCH/WAIT/LOAD. This gives a 3-cycle articulation gap between notes.
- PLAY:
  - Each clock, div_cnt decrements.
  - When div_cnt=0: reload tempo_div_latch and decrement ticks.
  - When div_cnt=0 and ticks=1 (last tick): index <- index+1, go to FETCH.
- Cycle counts:
  - Gate-high (or rest) length = ticks*(tempo_div+1) clocks.
  - Strobe-to-strobe period = ticks*(tempo_div+1)+3 clocks.
- Index wrap: if index is 2^IDX_W-1 at the end of PLAY, the next step is handled as END, with the same loop_en rule.
- loop_en is sampled at the LOAD of END, not at start.
- stop=1 in any state:
  - Next state IDLE; gate <- 0, busy <- 0; no done pulse.
  - note_pitch holds its last value.
  - stop wins over a simultaneous start.
- start while busy is ignored. song_sel and tempo_div changes while busy have no effect.
- tempo_div=0 is legal: one clock per tick.
- Reset mid-playback returns everything to reset values immediately (asynchronous).

Decomposition:
- Shared package (melody_pkg):
  - REST code 8'h80 and END code 6'h3F.
  - Duration code constants DUR_16TH..DUR_DOT8TH.
  - Pitch constants C4..A5.
  - Function dur_to_ticks(code) returning 5 bits.
  - FSM state enum.
- One natural sub-module, tick_timer: tempo divider plus tick down-counter, with load, expire and abort ports.
- The ROM content stays a separate module, extended to concatenate songs at {song, index}.

Test Plan:
- Test ROM, song 0: [E5/8th, REST/8th, A4/quarter, END]; tempo_div=3, loop_en=0, start.
  - Strobes 3 clocks after start.
  - pitch=7 with gate high for 8 clocks, then gate low 3 clocks.
  - REST strobe: gate low 8 clocks.
  - pitch=0 with gate high for 16 clocks.
  - done pulses 3 clocks after PLAY ends; busy falls with done.
- Same song with loop_en=1: after END, the next strobe shows pitch=7 again; index restarts at 0; no done pulse.
- song_sel=1 at start, then song_sel changed to 0 mid-song: rom_addr[MSB]=1 throughout playback.
- stop during PLAY of the second note: next cycle IDLE, gate=0, busy=0, no done. A new start is accepted and replays from index 0.
- start and stop in the same cycle while IDLE: stays IDLE. start pulsed while busy: no restart; strobe timing unchanged.
- Song with 128 non-END notes of code 0, tempo_div=0:
  - Index wraps at 127, which is treated as END.
  - Strobe period is 4 clocks.
- Async rst_n low mid-note: all outputs 0 immediately.
